// File: rtl/fpu_norm_arb.sv
// Shared normalization engine: two requesters arbitrate round-robin for a single
// leading-one detector and left shifter. Results return with the requester ID.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid_i/in_ready_o     per-requester operand handshake (ready one-hot, IDLE only)
//   in_mant_i/in_exp_i        packed per-requester mantissa/exponent, requester i at slice i
//   out_valid_o/out_ready_i   result handshake
//   out_id_o/out_mant_o/out_exp_o/out_zero_o/out_denorm_o  registered result

// Leading-one detector: first_one_o counts leading zeros from the MSB.
// Ports: in_i operand, first_one_o leading-zero count, no_ones_o operand is zero.
module fpu_ff #(
  parameter int unsigned LEN  = 24,
  parameter int unsigned LZ_W = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic [LEN-1:0]  in_i,
  output logic [LZ_W-1:0] first_one_o,
  output logic            no_ones_o
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    first_one_o = '0;
    for (int i = 0; i < LEN; i++) begin
      if (in_i[i]) first_one_o = LZ_W'(LEN - 1 - i);
    end
  end

  assign no_ones_o = ~|in_i;

endmodule

module fpu_norm_arb #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in_valid_i,
  output logic [1:0]          in_ready_o,
  input  logic [2*MANT_W-1:0] in_mant_i,
  input  logic [2*EXP_W-1:0]  in_exp_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_id_o,
  output logic [MANT_W-1:0]   out_mant_o,
  output logic [EXP_W-1:0]    out_exp_o,
  output logic                out_zero_o,
  output logic                out_denorm_o
);

  localparam int unsigned LZ_W = (MANT_W > 1) ? $clog2(MANT_W) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DETECT = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_rr_last;
  logic [MANT_W-1:0] r_op_mant;
  logic [EXP_W-1:0]  r_op_exp;
  logic              r_op_id;
  logic [LZ_W-1:0]   r_lz;
  logic              r_no_ones;

  logic              w_grant;
  logic              w_accept;
  logic [MANT_W-1:0] w_sel_mant;
  logic [EXP_W-1:0]  w_sel_exp;
  logic [LZ_W-1:0]   w_lz;
  logic              w_no_ones;
  logic [EXP_W-1:0]  w_sh;
  logic [MANT_W-1:0] w_res_mant;
  logic [EXP_W-1:0]  w_res_exp;
  logic              w_res_zero;
  logic              w_res_denorm;

  // Round-robin: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    case (in_valid_i)
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_rr_last;
      default: w_grant = 1'b0;
    endcase
  end

  assign w_accept   = (r_state == S_IDLE) && (|in_valid_i) && !rst;
  assign w_sel_mant = w_grant ? in_mant_i[2*MANT_W-1:MANT_W] : in_mant_i[MANT_W-1:0];
  assign w_sel_exp  = w_grant ? in_exp_i[2*EXP_W-1:EXP_W]    : in_exp_i[EXP_W-1:0];

  // Ready is one-hot on the granted requester, only while idle and out of reset.
  always_comb begin
    in_ready_o = 2'b00;
    if (w_accept) in_ready_o[w_grant] = 1'b1;
  end

  fpu_ff #(
    .LEN  (MANT_W),
    .LZ_W (LZ_W)
  ) u_ff (
    .in_i        (r_op_mant),
    .first_one_o (w_lz),
    .no_ones_o   (w_no_ones)
  );

  // Normalization result; when the exponent cannot absorb the full shift the
  // result is subnormal and the shift stops at exponent-1 (exp 0 means no shift).
  always_comb begin
    w_sh         = '0;
    w_res_mant   = '0;
    w_res_exp    = '0;
    w_res_zero   = 1'b0;
    w_res_denorm = 1'b0;
    if (r_no_ones) begin
      w_res_zero = 1'b1;
    end else if (r_op_exp > EXP_W'(r_lz)) begin
      w_res_mant = r_op_mant << r_lz;
      w_res_exp  = r_op_exp - EXP_W'(r_lz);
    end else begin
      w_sh         = (r_op_exp == '0) ? '0 : (r_op_exp - EXP_W'(1));
      w_res_mant   = r_op_mant << w_sh;
      w_res_denorm = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_DETECT;
      S_DETECT: w_state_nxt = S_SHIFT;
      S_SHIFT:  w_state_nxt = S_RESP;
      S_RESP:   if (out_ready_i) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Operand, detector and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last    <= 1'b1;
      r_op_mant    <= '0;
      r_op_exp     <= '0;
      r_op_id      <= 1'b0;
      r_lz         <= '0;
      r_no_ones    <= 1'b0;
      out_valid_o  <= 1'b0;
      out_id_o     <= 1'b0;
      out_mant_o   <= '0;
      out_exp_o    <= '0;
      out_zero_o   <= 1'b0;
      out_denorm_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_mant <= w_sel_mant;
            r_op_exp  <= w_sel_exp;
            r_op_id   <= w_grant;
            r_rr_last <= w_grant;
          end
        end
        S_DETECT: begin
          r_lz      <= w_lz;
          r_no_ones <= w_no_ones;
        end
        S_SHIFT: begin
          out_valid_o  <= 1'b1;
          out_id_o     <= r_op_id;
          out_mant_o   <= w_res_mant;
          out_exp_o    <= w_res_exp;
          out_zero_o   <= w_res_zero;
          out_denorm_o <= w_res_denorm;
        end
        S_RESP: begin
          if (out_ready_i) out_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
